// File: rtl/nibble_add_arbiter.sv
// Arbitrates two 4-bit adder requesters (round-robin or A-priority) onto one registered 5-bit sum.
// Latency: accept at edge k, result valid after edge k+1; readies stay low until the result handshake completes.
module nibble_add_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_x,
    input  logic [3:0] a_y,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_x,
    input  logic [3:0] b_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_sum,
    output logic       res_id,
    output logic [7:0] ops_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       last_grant;   // 1 = B was granted most recently
    logic       grant_b;
    logic       a_acc;
    logic       b_acc;
    logic       res_acc;

    logic [3:0] op_x;
    logic [3:0] op_y;
    logic       op_id;

    // Contention goes to whoever did not win last time, unless fixed priority is selected.
    always_comb begin
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_b = RR_EN && !last_grant;
        end else begin
            grant_b = b_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                a_ready = a_valid && !grant_b;
                b_ready = b_valid && grant_b;
                if (a_ready || b_ready) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign a_acc   = a_valid && a_ready;
    assign b_acc   = b_valid && b_ready;
    assign res_acc = res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and grant history move only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_x       <= 4'h0;
            op_y       <= 4'h0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (a_acc || b_acc) begin
            op_x       <= b_acc ? b_x : a_x;
            op_y       <= b_acc ? b_y : a_y;
            op_id      <= b_acc;
            last_grant <= b_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum <= 5'h00;
            res_id  <= 1'b0;
        end else if (state == EXEC) begin
            res_sum <= {1'b0, op_x} + {1'b0, op_y};
            res_id  <= op_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt <= 8'h00;
        end else if (res_acc) begin
            ops_cnt <= ops_cnt + 8'd1;
        end
    end

endmodule

// File: doc/nibble_add_arbiter.md
NIBBLE_ADD_ARBITER -- requirements
Module: nibble_add_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with A always winning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 a_valid  in  1  requester A holds operands valid.
REQ-005 a_ready  out  1  A request accepted this cycle.
REQ-006 a_x, a_y  in  4 each  requester A operands.
REQ-007 b_valid, b_ready, b_x, b_y  as REQ-004..006  requester B.
REQ-008 res_valid  out  1  result available.
REQ-009 res_ready  in  1  consumer accepts result.
REQ-010 res_sum  out  5  x + y, carry in bit 4.
REQ-011 res_id  out  1  source of result: 0 = A, 1 = B.
REQ-012 ops_cnt  out  8  count of completed result handshakes.

Function
REQ-013 FSM shall have three states: IDLE, EXEC, HOLD.
REQ-014 IDLE: grant computed from current valids; only the granted requester's ready shall be high, and only while its valid is high; all readies low in EXEC and HOLD.
REQ-015 Handshake = valid & ready at a rising edge; on it, latch operands and id, IDLE -> EXEC.
REQ-016 EXEC: register res_sum = x + y (unsigned, 5-bit, no truncation) and res_id; EXEC -> HOLD unconditionally.
REQ-017 HOLD: res_valid high; res_sum and res_id stable until handshake.
REQ-018 On res_valid & res_ready: HOLD -> IDLE, ops_cnt increments by 1.
REQ-019 Latency: request accepted at edge k, res_valid high after edge k+1; next ready no earlier than the cycle after the result handshake; minimum 3 cycles per operation.
REQ-020 Single valid requester: granted regardless of RR_EN.
REQ-021 Both valid, RR_EN=1: grant the requester not granted last; last_grant updates only on an accepted request.
REQ-022 Both valid, RR_EN=0: A always granted; B may starve.
REQ-023 Requester dropping valid before acceptance: no grant, no last_grant change.
REQ-024 res_ready high outside HOLD: ignored; ops_cnt unchanged.
REQ-025 ops_cnt wraps 255 -> 0 with no flag.
REQ-026 Sum edge: 4'hF + 4'hF = 5'h1E; 4'h0 + 4'h0 = 5'h00.

Reset
REQ-027 rst_n low shall immediately force state IDLE, res_valid 0, res_sum 0, res_id 0, ops_cnt 0, last_grant = B, so A wins the first contention.
REQ-028 Reset during EXEC or HOLD shall discard the in-flight operation; no result is emitted and ops_cnt stays 0.
REQ-029 After rst_n rises, the first acceptance may occur at the first rising edge.

Verification
REQ-030 A only, a_x=3, a_y=4, res_ready=1 -> a_ready high one cycle, res_sum=5'h07, res_id=0 two edges later, ops_cnt=1.
REQ-031 A and B held valid, RR_EN=1, res_ready=1 -> res_id sequence 0,1,0,1; ops_cnt=4 after 12 cycles.
REQ-032 Same stimulus, RR_EN=0 -> res_id always 0; b_ready never high.
REQ-033 B with x=F, y=F, res_ready=0 for 5 cycles -> res_valid held, res_sum=5'h1E stable, b_ready low, then release -> ops_cnt+1.
REQ-034 rst_n low while in HOLD -> res_valid and ops_cnt 0 immediately; no result after reset release without a new request.
REQ-035 256 completed operations -> ops_cnt returns to 0.
